williams_nvram_ctrl: RTL

WILLIAMS_NVRAM_CTRL -- requirements
Module: williams_nvram_ctrl

---
 rtl/williams_nvram_ctrl_if.sv | 34 +++
 rtl/williams_nvram_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/williams_nvram_ctrl_if.sv
// HPS ioctl / NVRAM port / CPU CMOS bundle for the Williams NVRAM controller.
// master = surrounding top level and RAM, slave = williams_nvram_ctrl.
interface williams_nvram_ctrl_if #(
   parameter int unsigned NV_AW = 10
);
   logic             ioctl_download;
   logic             ioctl_upload;
   logic [7:0]       ioctl_index;
   logic             ioctl_wr;
   logic             ioctl_rd;
   logic [24:0]      ioctl_addr;
   logic [7:0]       ioctl_dout;
   logic [7:0]       ioctl_din;
   logic             ioctl_wait;
   logic [NV_AW-1:0] nv_addr;
   logic [7:0]       nv_wdata;
   logic             nv_we;
   logic [7:0]       nv_rdata;
   logic             cpu_cmos_we;
   logic             nv_busy;
   logic             nv_dirty;

   modport master (
      output ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_rd, ioctl_addr,
             ioctl_dout, nv_rdata, cpu_cmos_we,
      input  ioctl_din, ioctl_wait, nv_addr, nv_wdata, nv_we, nv_busy, nv_dirty
   );

   modport slave (
      input  ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_rd, ioctl_addr,
             ioctl_dout, nv_rdata, cpu_cmos_we,
      output ioctl_din, ioctl_wait, nv_addr, nv_wdata, nv_we, nv_busy, nv_dirty
   );
endinterface

// File: rtl/williams_nvram_ctrl.sv
// Moves the CMOS/NVRAM image between the HPS ioctl channel and the NVRAM port,
// and tracks whether the CPU has changed CMOS since the last save or load.
module williams_nvram_ctrl #(
   parameter logic [7:0]  NV_INDEX = 8'd4,
   parameter int unsigned NV_AW    = 10,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   williams_nvram_ctrl_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StLoad, StUpIdle, StUpRd, StUpDone} state_e;

   localparam logic [1:0] LatLast = 2'(RD_LAT);

   state_e           state_q, state_d;
   logic             wait_q, wait_d;
   logic             we_q, we_d;
   logic [NV_AW-1:0] addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       din_q, din_d;
   logic             dirty_q, dirty_d;
   logic             pend_q, pend_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             oor_q, oor_d;

   logic index_hit;
   logic addr_in_range;

   assign index_hit     = (bus.ioctl_index == NV_INDEX);
   assign addr_in_range = ((bus.ioctl_addr >> NV_AW) == 25'd0);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      din_d   = din_q;
      dirty_d = dirty_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      oor_d   = oor_q;

      unique case (state_q)
         StIdle: begin
            if (bus.cpu_cmos_we) dirty_d = 1'b1;
            if (bus.ioctl_download && index_hit) begin
               state_d = StLoad;
            end else if (bus.ioctl_upload && index_hit) begin
               state_d = StUpIdle;
            end
         end

         StLoad: begin
            // A write coinciding with download dropping is dropped so nv_we stays inside LOAD.
            if (!bus.ioctl_download) begin
               state_d = StIdle;
               dirty_d = 1'b0;
            end else if (bus.ioctl_wr && addr_in_range) begin
               we_d    = 1'b1;
               addr_d  = bus.ioctl_addr[NV_AW-1:0];
               wdata_d = bus.ioctl_dout;
            end
         end

         StUpIdle: begin
            if (bus.cpu_cmos_we) pend_d = 1'b1;
            if (!bus.ioctl_upload) begin
               state_d = StUpDone;
               wait_d  = 1'b0;
            end else if (bus.ioctl_rd) begin
               state_d = StUpRd;
               wait_d  = 1'b1;
               addr_d  = bus.ioctl_addr[NV_AW-1:0];
               oor_d   = !addr_in_range;
               cnt_d   = 2'd0;
            end
         end

         StUpRd: begin
            if (bus.cpu_cmos_we) pend_d = 1'b1;
            if (!bus.ioctl_upload) begin
               state_d = StUpDone;
               wait_d  = 1'b0;
               cnt_d   = 2'd0;
            end else if (cnt_q == LatLast) begin
               state_d = StUpIdle;
               wait_d  = 1'b0;
               cnt_d   = 2'd0;
               din_d   = oor_q ? 8'hFF : bus.nv_rdata;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         StUpDone: begin
            // Saved image is now current; only writes seen during the upload remain dirty.
            dirty_d = pend_q | bus.cpu_cmos_we;
            pend_d  = 1'b0;
            wait_d  = 1'b0;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= StIdle;
         wait_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 8'h00;
         din_q   <= 8'h00;
         dirty_q <= 1'b0;
         pend_q  <= 1'b0;
         cnt_q   <= 2'd0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         din_q   <= din_d;
         dirty_q <= dirty_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         oor_q   <= oor_d;
      end
   end

   assign bus.ioctl_din  = din_q;
   assign bus.ioctl_wait = wait_q;
   assign bus.nv_addr    = addr_q;
   assign bus.nv_wdata   = wdata_q;
   assign bus.nv_we      = we_q;
   assign bus.nv_busy    = (state_q != StIdle);
   assign bus.nv_dirty   = dirty_q;

endmodule
